// File: rtl/node_ant_pkg.sv
// Packet format shared by the node shim and its network/core neighbours.
//   ant          : 1 = control ant, 0 = ordinary data packet
//   backward     : for ants, 1 = returning to origin, 0 = heading to destination
//   x/y_source   : originating node coordinates
//   x/y_dest     : destination node coordinates
//   x/y_memory   : route memory carried by ants (4 hops x 4 bits)
//   num_memories : number of valid entries in x/y_memory
//   payload      : data carried by data packets
package node_ant_pkg;

  typedef struct packed {
    logic        ant;
    logic        backward;
    logic [3:0]  x_source;
    logic [3:0]  y_source;
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [15:0] x_memory;
    logic [15:0] y_memory;
    logic [2:0]  num_memories;
    logic [15:0] payload;
  } packet_t;

endpackage

// File: rtl/node_ant_reflector.sv
// node_ant_reflector: ejection/injection shim between a node and its network
// port. Data packets from the network go to the core; forward ants are turned
// into backward ants and re-injected; backward ants are retired. Reflected ants
// share the network input with core traffic through a burst-limited arbiter.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   ej_data/ej_data_val/ej_en    network output side (ej_en is our ready)
//   core_rx_data/val/en          data packets to the core (en = core ready)
//   core_tx_data/val/en          core packets to inject (en = accepted)
//   inj_data/val/en              network input side (inj_en = network ready)
//   data_rx_cnt, ant_reflect_cnt, ant_return_cnt  saturating statistics
module node_ant_reflector
  import node_ant_pkg::*;
#(
  parameter int X_ID           = 0,
  parameter int Y_ID           = 0,
  parameter int ANT_FIFO_DEPTH = 4,
  parameter int MAX_ANT_BURST  = 4,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  packet_t          ej_data,
  input  logic             ej_data_val,
  output logic             ej_en,
  output packet_t          core_rx_data,
  output logic             core_rx_val,
  input  logic             core_rx_en,
  input  packet_t          core_tx_data,
  input  logic             core_tx_val,
  output logic             core_tx_en,
  output packet_t          inj_data,
  output logic             inj_data_val,
  input  logic             inj_en,
  output logic [CNT_W-1:0] data_rx_cnt,
  output logic [CNT_W-1:0] ant_reflect_cnt,
  output logic [CNT_W-1:0] ant_return_cnt
);

  localparam int AW = $clog2(ANT_FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(MAX_ANT_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_ANT_BURST);
  localparam logic [3:0]    X_SRC     = 4'(X_ID);
  localparam logic [3:0]    Y_SRC     = 4'(Y_ID);

  // Holds every output-driving path low for the first cycle after reset.
  logic active;

  packet_t        fifo_mem [ANT_FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic           fifo_full, fifo_empty;
  logic [BW-1:0]  burst_cnt;

  packet_t reflected;
  logic    ej_acc, acc_data, acc_fwd, acc_back;
  logic    ant_grant, grant_valid, ant_xfer, core_xfer, rx_pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr == {~rd_ptr[PW-1], rd_ptr[PW-2:0]});

  assign ej_en    = active && (!core_rx_val || core_rx_en) && !fifo_full;
  assign ej_acc   = ej_data_val && ej_en;
  assign acc_data = ej_acc && !ej_data.ant;
  assign acc_fwd  = ej_acc && ej_data.ant && !ej_data.backward;
  assign acc_back = ej_acc && ej_data.ant && ej_data.backward;
  assign rx_pop   = core_rx_val && core_rx_en;

  always_comb begin
    reflected          = ej_data;
    reflected.x_dest   = ej_data.x_source;
    reflected.y_dest   = ej_data.y_source;
    reflected.x_source = X_SRC;
    reflected.y_source = Y_SRC;
    reflected.backward = 1'b1;
  end

  // Core traffic only loses arbitration to the FIFO until the burst limit.
  assign ant_grant    = !fifo_empty && (!core_tx_val || (burst_cnt < BURST_MAX));
  assign grant_valid  = ant_grant || core_tx_val;
  assign inj_data_val = active && grant_valid && inj_en;
  assign inj_data     = ant_grant ? fifo_mem[rd_ptr[AW-1:0]] : core_tx_data;
  assign ant_xfer     = inj_data_val && ant_grant;
  assign core_xfer    = inj_data_val && !ant_grant;
  assign core_tx_en   = core_xfer;

  always_ff @(posedge clk) begin
    if (acc_fwd) fifo_mem[wr_ptr[AW-1:0]] <= reflected;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      active          <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      burst_cnt       <= '0;
      core_rx_val     <= 1'b0;
      core_rx_data    <= '0;
      data_rx_cnt     <= '0;
      ant_reflect_cnt <= '0;
      ant_return_cnt  <= '0;
    end else begin
      active <= 1'b1;
      if (acc_fwd)  wr_ptr <= wr_ptr + 1'b1;
      if (ant_xfer) rd_ptr <= rd_ptr + 1'b1;

      if (!core_tx_val || core_xfer) burst_cnt <= '0;
      else if (ant_xfer && burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;

      // A pop and a fresh load in the same cycle leave valid asserted.
      if (rx_pop) core_rx_val <= 1'b0;
      if (acc_data) begin
        core_rx_data <= ej_data;
        core_rx_val  <= 1'b1;
      end

      if (acc_data && data_rx_cnt != '1)     data_rx_cnt     <= data_rx_cnt + 1'b1;
      if (acc_fwd  && ant_reflect_cnt != '1) ant_reflect_cnt <= ant_reflect_cnt + 1'b1;
      if (acc_back && ant_return_cnt != '1)  ant_return_cnt  <= ant_return_cnt + 1'b1;
    end
  end

endmodule
